unity_rs_encoder: RTL and testbench
===================================

UNITY_RS_ENCODER -- requirements
Module: unity_rs_encoder

Interface
REQ-001 Parameter N_DATA, default 32, SHALL set the number of 8-bit data symbols per codeword (range 1..253).
REQ-002 Parameter SYM_W, default 8, SHALL set the symbol width; only 8 is supported.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 Port s_valid  input  1  SHALL mark s_data as valid.
REQ-006 Port s_ready  output  1  SHALL indicate the block accepts a data symbol this cycle.
REQ-007 Port s_data  input  8  SHALL carry one data symbol, highest-degree coefficient first.
REQ-008 Port m_valid  output  1  SHALL mark m_data as valid.
REQ-009 Port m_ready  input  1  SHALL indicate the downstream consumer takes m_data this cycle.
REQ-010 Port m_data  output  8  SHALL carry one codeword symbol: the data symbols in order, then 2 parity symbols.
REQ-011 Port m_last  output  1  SHALL be high with the final parity symbol of each codeword.
REQ-012 Port busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-013 Field arithmetic SHALL be GF(2^8) with primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1, so alpha=0x02 and alpha^8=0x5F.
REQ-014 The code SHALL be systematic with generator g(x)=(x+1)(x+alpha)=x^2+0x03*x+0x02.
REQ-015 Constant multipliers by 0x02 and 0x03 SHALL be pure XOR networks; no lookup table and no general multiplier.
REQ-016 Parity SHALL be computed by a 2-register LFSR (r1, r0) per accepted symbol d: fb=d^r1; r1<=r0^(0x03*fb); r0<=0x02*fb.
REQ-017 A transfer SHALL occur on s_valid&&s_ready (input) or m_valid&&m_ready (output); there are no other transfers.
REQ-018 s_ready SHALL equal (state==IDLE or state==DATA) && (!m_valid || m_ready).
REQ-019 Each accepted data symbol SHALL appear on m_data with m_valid=1 in the next cycle (latency 1, one output register).
REQ-020 m_data, m_valid and m_last SHALL hold stable while m_valid&&!m_ready.
REQ-021 The FSM SHALL have 4 states: IDLE, DATA, PAR1, PAR0.
REQ-022 IDLE->DATA on the first input transfer; the LFSR SHALL be cleared to 0 at this point, before the update for that symbol.
REQ-023 A symbol counter SHALL count input transfers 0..N_DATA-1; on the transfer with count N_DATA-1, the FSM SHALL go to PAR1.
REQ-024 In PAR1, when the output register is free, r1 SHALL be loaded to m_data (m_last=0) and the FSM SHALL go to PAR0.
REQ-025 In PAR0, when the output register is free, r0 SHALL be loaded with m_last=1 and the FSM SHALL go to IDLE.
REQ-026 s_ready SHALL be 0 in PAR1 and PAR0; back-to-back codewords SHALL resume in IDLE with no extra bubble beyond the 2 parity cycles.
REQ-027 For N_DATA=1, the FSM SHALL go from IDLE directly to PAR1 on the single input transfer.
REQ-028 The output register SHALL be free when m_valid==0 or m_ready==1; input load and drain SHALL be allowed in the same cycle.
REQ-029 s_data while s_valid==0, and m_ready while m_valid==0, SHALL have no effect.

Reset
REQ-030 With rst_n==0 at a clock edge: state=IDLE, counter=0, r1=r0=0, m_valid=0, m_last=0, m_data=0x00, busy=0.
REQ-031 Reset SHALL abort any partial codeword; no parity for it SHALL be emitted afterward.
REQ-032 s_ready SHALL be 0 while rst_n==0.

Verification
REQ-033 All-zero codeword: N_DATA=32, 32 x 0x00 -> output is 32 x 0x00, then 0x00, 0x00 (m_last on the last).
REQ-034 Single nonzero symbol: N_DATA=32, 31 x 0x00 then 0x01 -> parity 0x03, 0x02; the same with 0x02 last -> parity 0x06, 0x04.
REQ-035 Random data with random s_valid/m_ready stalls (over 1000 codewords) -> output data equals input, and the codeword polynomial evaluates to 0 at x=1 and x=0x02.
REQ-036 m_ready held low for 5 cycles during PAR1 output -> m_data holds 0x03 (REQ-034 case), then 0x02 follows after release; s_ready stays 0.
REQ-037 rst_n pulsed low after 10 symbols -> the next cycle shows m_valid=0 and busy=0; the next 32-symbol codeword yields parity identical to a fresh-start run.
REQ-038 Back-to-back codewords with s_valid and m_ready tied high -> a throughput of exactly 34 output symbols per 34 cycles after the initial 1-cycle latency.

Source files
------------

// File: rtl/unity_rs_encoder_if.sv
// Stream interface for the RS(N+2,N) encoder: one input symbol stream and one codeword output stream.
// The encoder takes the slave view; the producer/consumer side takes the master view.
interface unity_rs_encoder_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/unity_rs_encoder.sv
// Systematic GF(2^8) Reed-Solomon encoder, g(x) = (x+1)(x+alpha): passes N_DATA data symbols
// through a single output register, then appends the two LFSR parity symbols.
module unity_rs_encoder #(
    parameter int unsigned N_DATA = 32,
    parameter int unsigned SYM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    unity_rs_encoder_if.slave bus,
    output logic              busy
);

    localparam int unsigned    CNT_W    = (N_DATA > 1) ? $clog2(N_DATA) : 1;
    localparam logic [SYM_W-1:0] POLY_LOW = SYM_W'('h5F);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR1,
        S_PAR0
    } state_t;

    // Multiply by alpha: shift, fold x^8 back in as 0x5F.
    function automatic logic [SYM_W-1:0] gf_mul2(input logic [SYM_W-1:0] a);
        return {a[SYM_W-2:0], 1'b0} ^ ({SYM_W{a[SYM_W-1]}} & POLY_LOW);
    endfunction

    function automatic logic [SYM_W-1:0] gf_mul3(input logic [SYM_W-1:0] a);
        return gf_mul2(a) ^ a;
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SYM_W-1:0]   r_r1;
    logic [SYM_W-1:0]   r_r0;
    logic               r_m_valid;
    logic               r_m_last;
    logic [SYM_W-1:0]   r_m_data;
    logic               r_busy;

    logic               w_out_free;
    logic               w_in_xfer;
    logic               w_cnt_last;
    logic [SYM_W-1:0]   w_r1_base;
    logic [SYM_W-1:0]   w_r0_base;
    logic [SYM_W-1:0]   w_fb;
    logic [SYM_W-1:0]   w_r1_next;
    logic [SYM_W-1:0]   w_r0_next;

    assign w_out_free  = !r_m_valid || bus.m_ready;
    assign bus.s_ready = rst_n && ((r_state == S_IDLE) || (r_state == S_DATA)) && w_out_free;
    assign w_in_xfer   = bus.s_valid && bus.s_ready;
    assign w_cnt_last  = (r_cnt == CNT_W'(N_DATA - 1));

    // The first symbol of a codeword sees a cleared LFSR regardless of leftover parity.
    assign w_r1_base = (r_state == S_IDLE) ? '0 : r_r1;
    assign w_r0_base = (r_state == S_IDLE) ? '0 : r_r0;
    assign w_fb      = bus.s_data ^ w_r1_base;
    assign w_r1_next = w_r0_base ^ gf_mul3(w_fb);
    assign w_r0_next = gf_mul2(w_fb);

    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_last  = r_m_last;
    assign busy        = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_r1      <= '0;
            r_r0      <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_busy    <= 1'b0;
        end else if (w_in_xfer) begin
            r_r1      <= w_r1_next;
            r_r0      <= w_r0_next;
            r_m_data  <= bus.s_data;
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b0;
            r_busy    <= 1'b1;
            if (w_cnt_last) begin
                r_state <= S_PAR1;
                r_cnt   <= '0;
            end else begin
                r_state <= S_DATA;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end else if (w_out_free) begin
            unique case (r_state)
                S_PAR1: begin
                    r_m_data  <= r_r1;
                    r_m_valid <= 1'b1;
                    r_m_last  <= 1'b0;
                    r_state   <= S_PAR0;
                end
                S_PAR0: begin
                    r_m_data  <= r_r0;
                    r_m_valid <= 1'b1;
                    r_m_last  <= 1'b1;
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unity_rs_encoder.sv
// Scoreboard bench for unity_rs_encoder: expected codewords come from an independent
// syndrome-solving GF(2^8) model and are popped as the DUT emits symbols.
module tb_unity_rs_encoder;

    localparam int unsigned N = 32;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic busy1;

    unity_rs_encoder_if ifc();
    unity_rs_encoder_if ifc1();

    unity_rs_encoder #(.N_DATA(N), .SYM_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc),
        .busy  (busy)
    );

    unity_rs_encoder #(.N_DATA(1), .SYM_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1),
        .busy  (busy1)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic       mon_en = 1'b1;
    int         mready_mode = 0;
    logic [7:0] tx_buf [N];
    logic [7:0] syn1 = 8'h00;
    logic [7:0] syn2 = 8'h00;

    // General GF(2^8) multiply, poly 0x15F.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h5F) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        for (int i = 1; i < 256; i++)
            if (gmul(a, 8'(i)) == 8'h01) return 8'(i);
        return 8'h00;
    endfunction

    // Parity from c(1)=0 and c(alpha)=0: p1*(alpha+1) = S(1)^S(alpha), p0 = S(1)^p1.
    task automatic model_parity(output logic [7:0] p1, output logic [7:0] p0);
        logic [7:0] s1;
        logic [7:0] s2;
        s1 = 8'h00;
        s2 = 8'h00;
        for (int i = 0; i < N; i++) begin
            s1 = s1 ^ tx_buf[i];
            s2 = gmul(s2, 8'h02) ^ tx_buf[i];
        end
        s2 = gmul(gmul(s2, 8'h02), 8'h02);
        p1 = gmul(s1 ^ s2, ginv(8'h03));
        p0 = s1 ^ p1;
    endtask

    always @(posedge clk) begin
        #1;
        case (mready_mode)
            0:       ifc.m_ready = 1'b1;
            1:       ifc.m_ready = ($urandom_range(0, 7) != 0);
            default: ifc.m_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (mon_en && rst_n && ifc.m_valid && ifc.m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL out_unexpected: got %02h last=%0b, queue empty", ifc.m_data, ifc.m_last);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ifc.m_data, ifc.m_last} !== {mon_e.d, mon_e.last}) begin
                    n_errors++;
                    $display("FAIL out_symbol: got %02h last=%0b, expected %02h last=%0b",
                             ifc.m_data, ifc.m_last, mon_e.d, mon_e.last);
                end
            end
            syn1 = syn1 ^ ifc.m_data;
            syn2 = gmul(syn2, 8'h02) ^ ifc.m_data;
            if (ifc.m_last) begin
                n_checks++;
                if ((syn1 !== 8'h00) || (syn2 !== 8'h00)) begin
                    n_errors++;
                    $display("FAIL syndrome: got c(1)=%02h c(alpha)=%02h, expected 00 00", syn1, syn2);
                end
                syn1 = 8'h00;
                syn2 = 8'h00;
            end
        end
    end

    task automatic send_cw(input logic [7:0] p1, input logic [7:0] p0, input bit stalls, input bit cont);
        int guard;
        for (int i = 0; i < N; i++) exp_q.push_back('{d: tx_buf[i], last: 1'b0});
        exp_q.push_back('{d: p1, last: 1'b0});
        exp_q.push_back('{d: p0, last: 1'b1});
        for (int i = 0; i < N; i++) begin
            if (stalls && ($urandom_range(0, 7) == 0)) begin
                ifc.s_valid = 1'b0;
                ifc.s_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            ifc.s_valid = 1'b1;
            ifc.s_data  = tx_buf[i];
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!ifc.s_ready && guard < 500);
            if (!ifc.s_ready) begin
                n_checks++;
                n_errors++;
                $display("FAIL s_ready_timeout: got s_ready=0 after %0d cycles, expected 1", guard);
            end
            @(posedge clk);
            #1;
        end
        if (!cont) ifc.s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || ifc.m_valid) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_drain: got %0d pending busy=%0b, expected 0 pending busy=0",
                     name, exp_q.size(), busy);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        ifc.s_valid = 1'b1;
        ifc.s_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({ifc.m_valid, ifc.m_last, ifc.m_data, busy, ifc.s_ready} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_state: got v=%0b l=%0b d=%02h busy=%0b rdy=%0b, expected all 0",
                     ifc.m_valid, ifc.m_last, ifc.m_data, busy, ifc.s_ready);
        end
        n_checks++;
        if ({ifc1.m_valid, busy1, ifc1.s_ready} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state_n1: got v=%0b busy=%0b rdy=%0b, expected 0 0 0",
                     ifc1.m_valid, busy1, ifc1.s_ready);
        end
        @(posedge clk);
        #1;
        ifc.s_valid = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < N; i++) tx_buf[i] = 8'h00;
        send_cw(8'h00, 8'h00, 1'b0, 1'b0);
        wait_drain("all_zero");
    endtask

    task automatic test_single_nonzero();
        for (int i = 0; i < N; i++) tx_buf[i] = 8'h00;
        tx_buf[N-1] = 8'h01;
        send_cw(8'h03, 8'h02, 1'b0, 1'b0);
        wait_drain("single_01");
        tx_buf[N-1] = 8'h02;
        send_cw(8'h06, 8'h04, 1'b0, 1'b0);
        wait_drain("single_02");
    endtask

    task automatic test_par1_hold();
        for (int i = 0; i < N; i++) tx_buf[i] = 8'h00;
        tx_buf[N-1] = 8'h01;
        send_cw(8'h03, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        mready_mode = 2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ifc.m_valid, ifc.m_data, ifc.m_last, ifc.s_ready} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL par1_hold[%0d]: got v=%0b d=%02h l=%0b rdy=%0b, expected v=1 d=03 l=0 rdy=0",
                         k, ifc.m_valid, ifc.m_data, ifc.m_last, ifc.s_ready);
            end
        end
        mready_mode = 0;
        wait_drain("par1_hold");
    endtask

    task automatic test_reset_abort();
        logic [7:0] p1;
        logic [7:0] p0;
        mon_en = 1'b0;
        ifc.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ifc.s_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        ifc.s_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({ifc.m_valid, busy, ifc.s_ready} !== 3'b000) begin
            n_errors++;
            $display("FAIL abort_state: got v=%0b busy=%0b rdy=%0b, expected 0 0 0",
                     ifc.m_valid, busy, ifc.s_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ifc.m_valid, busy} !== 2'b00) begin
                n_errors++;
                $display("FAIL abort_no_parity[%0d]: got v=%0b busy=%0b, expected 0 0", k, ifc.m_valid, busy);
            end
        end
        @(posedge clk);
        #1;
        syn1 = 8'h00;
        syn2 = 8'h00;
        exp_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < N; i++) tx_buf[i] = 8'h00;
        tx_buf[N-1] = 8'h01;
        send_cw(8'h03, 8'h02, 1'b0, 1'b0);
        wait_drain("abort_fresh");
        for (int i = 0; i < N; i++) tx_buf[i] = 8'($urandom);
        model_parity(p1, p0);
        send_cw(p1, p0, 1'b0, 1'b0);
        wait_drain("abort_random");
    endtask

    task automatic test_back_to_back();
        int cnt;
        int guard;
        mready_mode = 0;
        cnt = 0;
        fork
            begin
                logic [7:0] p1;
                logic [7:0] p0;
                for (int k = 0; k < 4; k++) begin
                    for (int i = 0; i < N; i++) tx_buf[i] = 8'($urandom);
                    model_parity(p1, p0);
                    send_cw(p1, p0, 1'b0, k != 3);
                end
            end
            begin
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (!ifc.m_valid && guard < 100);
                for (int c = 0; c < 4 * (N + 2); c++) begin
                    if (ifc.m_valid && ifc.m_ready) cnt++;
                    @(negedge clk);
                end
            end
        join
        n_checks++;
        if (cnt != 4 * (N + 2)) begin
            n_errors++;
            $display("FAIL back_to_back_rate: got %0d outputs in %0d cycles, expected %0d",
                     cnt, 4 * (N + 2), 4 * (N + 2));
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_random_stalls();
        logic [7:0] p1;
        logic [7:0] p0;
        mready_mode = 1;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < N; i++) tx_buf[i] = 8'($urandom);
            model_parity(p1, p0);
            send_cw(p1, p0, 1'b1, k != 999);
        end
        mready_mode = 0;
        wait_drain("random_stalls");
    endtask

    task automatic test_n1();
        ifc1.s_valid = 1'b1;
        ifc1.s_data  = 8'h01;
        @(negedge clk);
        n_checks++;
        if (ifc1.s_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL n1_ready: got %0b, expected 1", ifc1.s_ready);
        end
        @(posedge clk);
        #1;
        ifc1.s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ifc1.m_valid, ifc1.m_data, ifc1.m_last, ifc1.s_ready, busy1} !== {1'b1, 8'h01, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL n1_data: got v=%0b d=%02h l=%0b rdy=%0b busy=%0b, expected 1 01 0 0 1",
                     ifc1.m_valid, ifc1.m_data, ifc1.m_last, ifc1.s_ready, busy1);
        end
        @(negedge clk);
        n_checks++;
        if ({ifc1.m_valid, ifc1.m_data, ifc1.m_last} !== {1'b1, 8'h03, 1'b0}) begin
            n_errors++;
            $display("FAIL n1_par1: got v=%0b d=%02h l=%0b, expected 1 03 0",
                     ifc1.m_valid, ifc1.m_data, ifc1.m_last);
        end
        @(negedge clk);
        n_checks++;
        if ({ifc1.m_valid, ifc1.m_data, ifc1.m_last} !== {1'b1, 8'h02, 1'b1}) begin
            n_errors++;
            $display("FAIL n1_par0: got v=%0b d=%02h l=%0b, expected 1 02 1",
                     ifc1.m_valid, ifc1.m_data, ifc1.m_last);
        end
        @(negedge clk);
        n_checks++;
        if ({ifc1.m_valid, busy1} !== 2'b00) begin
            n_errors++;
            $display("FAIL n1_idle: got v=%0b busy=%0b, expected 0 0", ifc1.m_valid, busy1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifc.s_valid   = 1'b0;
        ifc.s_data    = 8'h00;
        ifc1.s_valid  = 1'b0;
        ifc1.s_data   = 8'h00;
        ifc1.m_ready  = 1'b1;
        test_reset();
        test_all_zero();
        test_single_nonzero();
        test_par1_hold();
        test_reset_abort();
        test_back_to_back();
        test_n1();
        test_random_stalls();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
